// File: rtl/pool_pingpong_ctrl_pkg.sv
// pool_pingpong_ctrl_pkg: shared constants, reader states and window address helper for 2x2 pooling.
package pool_pingpong_ctrl_pkg;
  localparam int POOL_K = 2;
  localparam int BANKS = 2;
  localparam int ROW_W_DEFAULT = 8;
  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} rd_state_t;
  // Offset inside a bank of tap `phase` of window `col`: phases 0/1 top row, 2/3 bottom row.
  function automatic logic [15:0] win_off(input logic [15:0] col, input logic [1:0] phase, input int row_w);
    return (phase[1] ? 16'(row_w) : 16'd0) + {col[14:0], phase[0]};
  endfunction
endpackage

// File: rtl/pool_pingpong_ctrl_max_acc.sv
// pool_max_acc: aligns read tags with registered RAM data and keeps the running unsigned 2x2 max.
module pool_max_acc #(
  parameter int DATA_W = 8,
  parameter int COL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              rd_en,
  input  logic [1:0]        phase,
  input  logic [COL_W-1:0]  col,
  input  logic [DATA_W-1:0] d,
  output logic              pool_valid,
  output logic [DATA_W-1:0] pool_data,
  output logic [COL_W-1:0]  pool_col
);
  logic tag_v;
  logic [1:0] tag;
  logic [COL_W-1:0] tag_col;
  logic [DATA_W-1:0] acc, mx;
  assign mx = (acc > d) ? acc : d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tag_v <= 1'b0;
      tag <= '0;
      tag_col <= '0;
      acc <= '0;
      pool_valid <= 1'b0;
      pool_data <= '0;
      pool_col <= '0;
    end else if (clr) begin
      tag_v <= 1'b0;
      tag <= '0;
      tag_col <= '0;
      acc <= '0;
      pool_valid <= 1'b0;
      pool_data <= '0;
      pool_col <= '0;
    end else begin
      tag_v <= rd_en;
      tag <= phase;
      tag_col <= col;
      pool_valid <= tag_v && tag == 2'd3;
      if (tag_v) acc <= (tag == 2'd0) ? d : mx;
      if (tag_v && tag == 2'd3) begin
        pool_data <= mx;
        pool_col <= tag_col;
      end
    end
endmodule

// File: rtl/pool_pingpong_ctrl.sv
// pool_pingpong_ctrl: fills one RAM bank with two conv rows while the other is scanned as 2x2 max windows.
module pool_pingpong_ctrl
  import pool_pingpong_ctrl_pkg::*;
#(
  parameter int ROW_W = ROW_W_DEFAULT,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  localparam int COL_W = (ROW_W > POOL_K) ? $clog2(ROW_W / POOL_K) : 1,
  localparam int PTR_W = $clog2(2 * ROW_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_d_in,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_d_out,
  output logic              pool_valid,
  output logic [DATA_W-1:0] pool_data,
  output logic [COL_W-1:0]  pool_col
);
  rd_state_t state, state_nxt;
  logic wr_bank, rd_bank, wr_last, last_rd;
  logic [BANKS-1:0] full;
  logic [PTR_W-1:0] wr_ptr;
  logic [COL_W-1:0] col;
  logic [1:0] phase;
  assign in_ready = !full[wr_bank];
  assign ram_wr_en = in_valid && in_ready && !frame_start;
  assign ram_wr_addr = ADDR_W'({wr_bank, wr_ptr});
  assign ram_d_in = in_data;
  assign ram_rd_en = state == SCAN && !frame_start;
  assign ram_rd_addr = ram_rd_en ? ADDR_W'({rd_bank, PTR_W'(win_off(16'(col), phase, ROW_W))}) : '0;
  assign wr_last = ram_wr_en && wr_ptr == PTR_W'(2 * ROW_W - 1);
  assign last_rd = state == SCAN && col == COL_W'(ROW_W / 2 - 1) && phase == 2'd3;
  // FLUSH holds off the next bank until the last window's result has left the accumulator.
  always_comb begin
    state_nxt = state == IDLE ? (full[rd_bank] ? SCAN : IDLE)
              : state == SCAN ? (last_rd ? FLUSH : SCAN)
              : pool_valid ? (full[rd_bank] ? SCAN : IDLE) : FLUSH;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full <= '0;
      wr_ptr <= '0;
      col <= '0;
      phase <= '0;
    end else if (frame_start) begin
      state <= IDLE;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full <= '0;
      wr_ptr <= '0;
      col <= '0;
      phase <= '0;
    end else begin
      state <= state_nxt;
      if (ram_wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (wr_last) wr_bank <= !wr_bank;
      if (last_rd) rd_bank <= !rd_bank;
      full <= (full | (BANKS'(wr_last) << wr_bank)) & ~(BANKS'(last_rd) << rd_bank);
      if (state == SCAN) begin
        phase <= phase + 1'b1;
        col <= col + COL_W'(phase == 2'd3);
      end
    end
  pool_max_acc #(.DATA_W(DATA_W), .COL_W(COL_W)) u_acc (
    .clk(clk),
    .rst(rst),
    .clr(frame_start),
    .rd_en(ram_rd_en),
    .phase(phase),
    .col(col),
    .d(ram_d_out),
    .pool_valid(pool_valid),
    .pool_data(pool_data),
    .pool_col(pool_col)
  );
endmodule

// File: tb/tb_pool_pingpong_ctrl.sv
// tb_pool_pingpong_ctrl: scoreboard bench with a behavioural ping-pong RAM for pool_pingpong_ctrl.
module tb_pool_pingpong_ctrl;
  localparam int ROW_W = 8, DATA_W = 8, ADDR_W = 7, N = 2 * ROW_W;
  typedef struct {int data; int col;} res_t;
  logic clk = 0, rst = 0, frame_start = 0, in_valid = 0;
  logic [DATA_W-1:0] in_data = 0;
  logic in_ready, ram_wr_en, ram_rd_en, pool_valid;
  logic [ADDR_W-1:0] ram_wr_addr, ram_rd_addr;
  logic [DATA_W-1:0] ram_d_in, ram_d_out, pool_data;
  logic [1:0] pool_col;
  logic [DATA_W-1:0] mem [128];
  logic [DATA_W-1:0] stim [64];
  logic [DATA_W-1:0] grp [N];
  res_t exp_q[$];
  int rd_q[$];
  bit pend [2];
  int total = 0, bad = 0, cyc = 0, wcnt, wgrp, first_rd, stalls, npool, a_exp;
  bit seen_rd, seen_pv;
  pool_pingpong_ctrl #(.ROW_W(ROW_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_d_in(ram_d_in),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_d_out(ram_d_out),
    .pool_valid(pool_valid), .pool_data(pool_data), .pool_col(pool_col)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_d_in;
  always @(posedge clk or negedge rst)
    if (!rst) ram_d_out <= 0;
    else ram_d_out <= ram_rd_en ? mem[ram_rd_addr] : 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task clear_model;
    wcnt = 0; wgrp = 0; exp_q.delete(); rd_q.delete(); pend = '{default: 0};
    seen_rd = 0; seen_pv = 0; stalls = 0; npool = 0;
  endtask
  // A completed bank yields its expected window maxima and the read order the reader must follow.
  task push_bank(input int b);
    int m;
    for (int c = 0; c < ROW_W / 2; c++) begin
      m = grp[2*c];
      if (grp[2*c+1] > m) m = grp[2*c+1];
      if (grp[ROW_W+2*c] > m) m = grp[ROW_W+2*c];
      if (grp[ROW_W+2*c+1] > m) m = grp[ROW_W+2*c+1];
      exp_q.push_back('{m, c});
      rd_q.push_back(b*N + 2*c);
      rd_q.push_back(b*N + 2*c + 1);
      rd_q.push_back(b*N + ROW_W + 2*c);
      rd_q.push_back(b*N + ROW_W + 2*c + 1);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (!rst) clear_model();
    else begin
      chk("in_ready", in_ready, !pend[wgrp%2]);
      if (in_valid && !in_ready) stalls++;
      if (ram_wr_en) begin
        chk("wr_addr", ram_wr_addr, (wgrp%2)*N + wcnt);
        chk("wr_data", ram_d_in, in_data);
        grp[wcnt] = in_data;
        wcnt++;
        if (wcnt == N) begin
          push_bank(wgrp%2);
          pend[wgrp%2] = 1;
          wgrp++;
          wcnt = 0;
        end
      end
      if (ram_rd_en) begin
        if (!seen_rd) begin first_rd = cyc; seen_rd = 1; end
        if (rd_q.size() == 0) chk("rd_unexp", ram_rd_en, 0);
        else begin
          a_exp = rd_q.pop_front();
          chk("rd_addr", ram_rd_addr, a_exp);
          if (a_exp % N == N - 1) pend[a_exp/N] = 0;
        end
      end
      if (pool_valid) begin
        npool++;
        if (!seen_pv) begin chk("latency", cyc - first_rd, 5); seen_pv = 1; end
        if (exp_q.size() == 0) chk("pool_unexp", pool_valid, 0);
        else begin
          chk("pool_data", pool_data, exp_q[0].data);
          chk("pool_col", pool_col, exp_q[0].col);
          void'(exp_q.pop_front());
        end
      end
      if (frame_start) clear_model();
    end
  end
  task automatic stream(input int n);
    int i = 0, guard = 0;
    while (i < n && guard < 1000) begin
      in_valid = 1; in_data = stim[i];
      @(negedge clk);
      if (in_ready) i++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 0;
    chk("stream_done", i, n);
  endtask
  task automatic drain;
    int g = 0;
    while ((exp_q.size() != 0 || rd_q.size() != 0) && g < 300) begin @(posedge clk); g++; end
    repeat (4) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
  endtask
  task automatic restart;
    frame_start = 1;
    @(posedge clk); #1;
    frame_start = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_pool_valid", pool_valid, 0);
    chk("rst_pool_data", pool_data, 0);
    chk("rst_pool_col", pool_col, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) stim[i] = DATA_W'(i);
    stream(N);
    drain();
    chk("single_n", npool, ROW_W / 2);
    restart();
    for (int i = 0; i < 2*N; i++) stim[i] = DATA_W'($urandom_range(0, 255));
    stream(2*N);
    chk("pp_no_stall", stalls, 0);
    drain();
    chk("pp_n", npool, ROW_W);
    restart();
    for (int i = 0; i < 3*N; i++) stim[i] = DATA_W'($urandom_range(0, 255));
    stream(3*N);
    chk("bp_stalled", stalls > 0, 1);
    drain();
    chk("bp_n", npool, 3 * ROW_W / 2);
    restart();
    for (int i = 0; i < N; i++) stim[i] = DATA_W'($urandom_range(0, 255));
    stim[0] = 200; stim[1] = 3; stim[ROW_W] = 255; stim[ROW_W+1] = 17;
    stim[2] = 0; stim[3] = 0; stim[ROW_W+2] = 0; stim[ROW_W+3] = 0;
    stream(N);
    drain();
    chk("max_n", npool, ROW_W / 2);
    restart();
    for (int i = 0; i < N + 4; i++) stim[i] = DATA_W'(i + 1);
    stream(N + 4);
    restart();
    repeat (20) @(posedge clk);
    #1;
    chk("fs_npool", npool, 0);
    chk("fs_rd_en", ram_rd_en, 0);
    chk("fs_in_ready", in_ready, 1);
    stim[0] = 8'd77;
    stream(1);
    restart();
    for (int i = 0; i < N + 4; i++) stim[i] = DATA_W'(i * 3);
    stream(N + 4);
    #2 rst = 0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_pool_valid", pool_valid, 0);
    chk("arst_rd_en", ram_rd_en, 0);
    chk("arst_wr_en", ram_wr_en, 0);
    @(posedge clk); #1;
    rst = 1;
    repeat (20) @(posedge clk);
    #1;
    chk("arst_npool", npool, 0);
    chk("arst_idle", ram_rd_en, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
